// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the buffered UART transmitter:
//   - parity mode encodings (PAR_NONE / PAR_ODD / PAR_EVEN)
//   - transmit FSM state enumeration
//   - clog2 helper for sizing pointers and counters
//   - frame_parity helper that turns a data word into its parity bit
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_t;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Parity bit for a (zero-extended) data word; zero padding does not
    // change the XOR, so one helper serves every DATA_BITS setting.
    function automatic logic frame_parity(input logic [8:0] data, input logic [1:0] mode);
        logic p;
        case (mode)
            PAR_ODD:  p = ~^data;
            PAR_EVEN: p = ^data;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_sync_fifo
// Generic single-clock FIFO, first-word-fall-through read port.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (clears pointers, count, storage)
//   push   in   write request, ignored while full
//   pop    in   read request, ignored while empty
//   wdata  in   WIDTH  write data
//   rdata  out  WIDTH  head entry (valid while empty=0)
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  log2(DEPTH)+1 bits, registered occupancy
// -----------------------------------------------------------------------------
module uart_tx_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    output logic                      full,
    output logic                      empty,
    output logic [clog2(DEPTH):0]     count
);

    localparam int AW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
    localparam int CW = clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Full/empty come from the registered count, so a push on a full edge is
    // refused even if a pop happens on that same edge.
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;
    assign rdata = mem_r[rd_ptr_r];

    // Storage, pointers (wrap modulo DEPTH) and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_ctrl
// Buffered UART transmitter: write FIFO, configurable frame format, internal
// baud divider and CTS flow control.
// Ports:
//   ser_clk     in   clock
//   sys_rst_i   in   asynchronous active-low reset (aborts any frame)
//   uart_wr_i   in   write strobe, accepted when uart_full=0
//   uart_dat_i  in   DATA_BITS write data
//   uart_cts_i  in   clear-to-send; checked only in IDLE and at end of STOP
//   uart_tx     out  serial line, idle high
//   uart_busy   out  FIFO non-empty or frame in progress
//   uart_full   out  FIFO full
//   uart_empty  out  FIFO empty
//   uart_ovf    out  one-cycle pulse after a write was dropped (FIFO full)
//   uart_rts    out  one-cycle pulse after a byte was loaded into the shifter
// -----------------------------------------------------------------------------
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 ser_clk,
    input  logic                 sys_rst_i,
    input  logic                 uart_wr_i,
    input  logic [DATA_BITS-1:0] uart_dat_i,
    input  logic                 uart_cts_i,
    output logic                 uart_tx,
    output logic                 uart_busy,
    output logic                 uart_full,
    output logic                 uart_empty,
    output logic                 uart_ovf,
    output logic                 uart_rts
);

    localparam int CNT_W  = clog2(FIFO_DEPTH) + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
    localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [1:0]        PAR_MODE  = 2'(PARITY);

    uart_state_t          state_r;
    uart_state_t          state_nxt_s;
    logic [BAUD_W-1:0]    baud_cnt_r;
    logic [BAUD_W-1:0]    baud_nxt_s;
    logic [3:0]           bit_cnt_r;
    logic [3:0]           bit_nxt_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_nxt_s;
    logic                 par_r;
    logic                 par_nxt_s;
    logic                 tx_r;
    logic                 tx_nxt_s;
    logic                 ovf_r;
    logic                 rts_r;

    logic                 load_s;
    logic                 bit_done_s;
    logic                 start_ok_s;
    logic [DATA_BITS-1:0] fifo_rdata_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [CNT_W-1:0]     fifo_count_s;

    uart_tx_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ser_clk),
        .rst_n (sys_rst_i),
        .push  (uart_wr_i),
        .pop   (load_s),
        .wdata (uart_dat_i),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign bit_done_s = (baud_cnt_r == BAUD_LAST);
    assign start_ok_s = ~fifo_empty_s & uart_cts_i;

    assign uart_tx    = tx_r;
    assign uart_ovf   = ovf_r;
    assign uart_rts   = rts_r;
    assign uart_full  = fifo_full_s;
    assign uart_empty = fifo_empty_s;
    assign uart_busy  = (fifo_count_s != {CNT_W{1'b0}}) | (state_r != ST_IDLE);

    // FSM state register.
    always_ff @(posedge ser_clk or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; load_s pops the FIFO head into the shifter. The end of
    // STOP may reload directly so back-to-back frames have no idle gap.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = ST_START;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done_s && (bit_cnt_r == DATA_LAST)) begin
                    state_nxt_s = (PAR_MODE != PAR_NONE) ? ST_PAR : ST_STOP;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PAR: begin
                if (bit_done_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PAR;
                end
            end
            ST_STOP: begin
                if (bit_done_s && (bit_cnt_r == STOP_LAST)) begin
                    if (start_ok_s) begin
                        state_nxt_s = ST_START;
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values: line level, baud and bit counters,
    // shifter and latched parity. Counters restart on every bit boundary.
    always_comb begin
        tx_nxt_s    = tx_r;
        baud_nxt_s  = baud_cnt_r;
        bit_nxt_s   = bit_cnt_r;
        shift_nxt_s = shift_r;
        par_nxt_s   = par_r;
        if (load_s) begin
            tx_nxt_s    = 1'b0;
            baud_nxt_s  = BAUD_ZERO;
            bit_nxt_s   = 4'd0;
            shift_nxt_s = fifo_rdata_s;
            par_nxt_s   = frame_parity(9'(fifo_rdata_s), PAR_MODE);
        end else if (state_r == ST_IDLE) begin
            tx_nxt_s   = 1'b1;
            baud_nxt_s = BAUD_ZERO;
            bit_nxt_s  = 4'd0;
        end else if (bit_done_s) begin
            baud_nxt_s = BAUD_ZERO;
            bit_nxt_s  = (state_nxt_s == state_r) ? (bit_cnt_r + 4'd1) : 4'd0;
            case (state_nxt_s)
                ST_DATA: begin
                    // LSB first: present bit 0, then move the next bit down.
                    tx_nxt_s    = shift_r[0];
                    shift_nxt_s = {1'b0, shift_r[DATA_BITS-1:1]};
                end
                ST_PAR: begin
                    tx_nxt_s = par_r;
                end
                default: begin
                    tx_nxt_s = 1'b1;
                end
            endcase
        end else begin
            baud_nxt_s = baud_cnt_r + BAUD_W'(1'b1);
        end
    end

    // Datapath and output registers.
    always_ff @(posedge ser_clk or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            baud_cnt_r <= BAUD_ZERO;
            bit_cnt_r  <= 4'd0;
            shift_r    <= {DATA_BITS{1'b0}};
            par_r      <= 1'b0;
            tx_r       <= 1'b1;
            ovf_r      <= 1'b0;
            rts_r      <= 1'b0;
        end else begin
            baud_cnt_r <= baud_nxt_s;
            bit_cnt_r  <= bit_nxt_s;
            shift_r    <= shift_nxt_s;
            par_r      <= par_nxt_s;
            tx_r       <= tx_nxt_s;
            ovf_r      <= uart_wr_i & fifo_full_s;
            rts_r      <= load_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_ctrl
// Four transmitter configurations side by side, each shadowed by a
// behavioural model that expands every started frame into its per-cycle line
// levels. One compare process checks all outputs on every falling clock edge;
// directed sequences add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_ctrl;

    localparam int NCFG  = 4;
    localparam int DEPTH = 4;
    localparam int CFG_DB   [NCFG] = '{8, 8, 8, 7};
    localparam int CFG_PAR  [NCFG] = '{0, 2, 1, 0};
    localparam int CFG_STOP [NCFG] = '{1, 2, 1, 1};
    localparam int CFG_CPB  [NCFG] = '{4, 4, 1, 1};

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [NCFG-1:0] wr    = '0;
    logic [NCFG-1:0] cts   = '0;
    logic [8:0]      dat [NCFG];

    logic [NCFG-1:0] tx_v, busy_v, full_v, empty_v, ovf_v, rts_v;
    logic [NCFG-1:0] e_tx, e_busy, e_full, e_empty, e_ovf, e_rts;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : gen_cfg
        localparam int DB   = CFG_DB[g];
        localparam int PAR  = CFG_PAR[g];
        localparam int STOP = CFG_STOP[g];
        localparam int CPB  = CFG_CPB[g];

        uart_tx_fifo_ctrl #(
            .DATA_BITS    (DB),
            .PARITY       (PAR),
            .STOP_BITS    (STOP),
            .CLKS_PER_BIT (CPB),
            .FIFO_DEPTH   (DEPTH)
        ) dut (
            .ser_clk    (clk),
            .sys_rst_i  (rst_n),
            .uart_wr_i  (wr[g]),
            .uart_dat_i (dat[g][DB-1:0]),
            .uart_cts_i (cts[g]),
            .uart_tx    (tx_v[g]),
            .uart_busy  (busy_v[g]),
            .uart_full  (full_v[g]),
            .uart_empty (empty_v[g]),
            .uart_ovf   (ovf_v[g]),
            .uart_rts   (rts_v[g])
        );

        // Model: a queue of pending bytes plus the remaining line levels of
        // the frame on the wire (one entry per clock cycle).
        logic [8:0] q [$];
        bit         wave [$];
        logic       m_tx = 1'b1, m_busy = 1'b0, m_full = 1'b0;
        logic       m_empty = 1'b1, m_ovf = 1'b0, m_rts = 1'b0;
        int         pre_n;
        logic [8:0] d_n;
        bit         par_n;
        bit         start_n;

        assign e_tx[g]    = m_tx;
        assign e_busy[g]  = m_busy;
        assign e_full[g]  = m_full;
        assign e_empty[g] = m_empty;
        assign e_ovf[g]   = m_ovf;
        assign e_rts[g]   = m_rts;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q.delete();
                wave.delete();
                m_tx    <= 1'b1;
                m_busy  <= 1'b0;
                m_full  <= 1'b0;
                m_empty <= 1'b1;
                m_ovf   <= 1'b0;
                m_rts   <= 1'b0;
            end else begin
                pre_n   = q.size();
                start_n = 1'b0;
                if (wave.size() > 0) void'(wave.pop_front());
                if (wave.size() == 0 && pre_n > 0 && cts[g]) begin
                    d_n     = q.pop_front();
                    start_n = 1'b1;
                    for (int c = 0; c < CPB; c++) wave.push_back(1'b0);
                    for (int b = 0; b < DB; b++)
                        for (int c = 0; c < CPB; c++) wave.push_back(d_n[b]);
                    if (PAR != 0) begin
                        par_n = (PAR == 2) ? (($countones(d_n) % 2) == 1) : (($countones(d_n) % 2) == 0);
                        for (int c = 0; c < CPB; c++) wave.push_back(par_n);
                    end
                    for (int c = 0; c < STOP * CPB; c++) wave.push_back(1'b1);
                end
                if (wr[g] && pre_n < DEPTH) q.push_back(9'(dat[g][DB-1:0]));
                m_ovf   <= wr[g] && (pre_n == DEPTH);
                m_rts   <= start_n;
                m_tx    <= (wave.size() != 0) ? wave[0] : 1'b1;
                m_busy  <= (q.size() != 0) || (wave.size() != 0);
                m_full  <= (q.size() == DEPTH);
                m_empty <= (q.size() == 0);
            end
        end
    end

    // Every-cycle comparison of all configurations against the model.
    always @(negedge clk) begin
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("tx[%0d]", g),    int'(tx_v[g]),    int'(e_tx[g]));
            check($sformatf("busy[%0d]", g),  int'(busy_v[g]),  int'(e_busy[g]));
            check($sformatf("full[%0d]", g),  int'(full_v[g]),  int'(e_full[g]));
            check($sformatf("empty[%0d]", g), int'(empty_v[g]), int'(e_empty[g]));
            check($sformatf("ovf[%0d]", g),   int'(ovf_v[g]),   int'(e_ovf[g]));
            check($sformatf("rts[%0d]", g),   int'(rts_v[g]),   int'(e_rts[g]));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int g, input int limit);
        int k;
        k = 0;
        while (busy_v[g] && k < limit) begin
            tick(1);
            k++;
        end
        check($sformatf("drain_busy[%0d]", g), int'(busy_v[g]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] seq10;
        logic [8:0] seq9;
        int         rts_n;
        int         low_n;

        for (int i = 0; i < NCFG; i++) dat[i] = 9'h000;
        #2 rst_n = 1'b0;
        tick(3);
        check("rst_tx",    int'(tx_v),    4'hF);
        check("rst_busy",  int'(busy_v),  4'h0);
        check("rst_empty", int'(empty_v), 4'hF);
        check("rst_full",  int'(full_v),  4'h0);
        check("rst_pulse", int'(ovf_v | rts_v), 4'h0);
        rst_n = 1'b1;
        tick(2);

        // Default format, 4 clocks per bit, 0xA5.
        cts[0] = 1'b1;
        wr[0]  = 1'b1;
        dat[0] = 9'h0A5;
        tick(1);
        wr[0] = 1'b0;
        check("a_tx_after_e0", tx_v[0], 1);
        check("a_empty_after_e0", empty_v[0], 0);
        tick(1);
        check("a_rts", rts_v[0], 1);
        seq10[0] = tx_v[0];
        for (int b = 1; b < 10; b++) begin
            tick(4);
            seq10[b] = tx_v[0];
        end
        check("a_frame_bits", seq10, 10'b1101001010);
        tick(3);
        check("a_busy_last_cycle", busy_v[0], 1);
        tick(1);
        check("a_busy_done", busy_v[0], 0);
        check("a_tx_idle", tx_v[0], 1);

        // Parity and two stop bits; second byte queued on cfg1.
        cts[1] = 1'b1;
        cts[2] = 1'b1;
        wr[1]  = 1'b1;
        wr[2]  = 1'b1;
        dat[1] = 9'h0A5;
        dat[2] = 9'h0A5;
        tick(1);
        wr[2]  = 1'b0;
        dat[1] = 9'h03C;
        tick(1);
        wr[1] = 1'b0;
        tick(9);
        check("b_odd_parity", tx_v[2], 1);
        tick(28);
        check("b_even_parity", tx_v[1], 0);
        tick(10);
        check("b_stop2_high", tx_v[1], 1);
        tick(1);
        check("b_next_start", tx_v[1], 0);
        check("b_next_rts", rts_v[1], 1);
        wait_idle(1, 100);
        wait_idle(2, 10);

        // Overflow with CTS held low, then four gapless frames.
        cts[0] = 1'b0;
        wr[0]  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dat[0] = 9'(8'h11 * (i + 1));
            tick(1);
            if (i == 3) check("c_full_after_4", full_v[0], 1);
        end
        wr[0] = 1'b0;
        check("c_ovf_pulse", ovf_v[0], 1);
        tick(1);
        check("c_ovf_single", ovf_v[0], 0);
        check("c_tx_held", tx_v[0], 1);
        cts[0] = 1'b1;
        rts_n  = 0;
        low_n  = 0;
        for (int i = 0; i < 160; i++) begin
            tick(1);
            rts_n += int'(rts_v[0]);
            if (!busy_v[0]) low_n++;
        end
        check("c_rts_count", rts_n, 4);
        check("c_no_gap", low_n, 0);
        tick(1);
        check("c_busy_end", busy_v[0], 0);
        check("c_empty_end", empty_v[0], 1);

        // CTS dropped mid-frame: frame completes, next start withheld.
        wr[0]  = 1'b1;
        dat[0] = 9'h0C3;
        tick(1);
        dat[0] = 9'h05A;
        tick(1);
        wr[0] = 1'b0;
        check("d_rts", rts_v[0], 1);
        tick(10);
        cts[0] = 1'b0;
        tick(30);
        check("d_tx_idle", tx_v[0], 1);
        check("d_busy_pending", busy_v[0], 1);
        rts_n = 0;
        low_n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            rts_n += int'(rts_v[0]);
            if (!tx_v[0]) low_n++;
        end
        check("d_withheld_rts", rts_n, 0);
        check("d_withheld_tx", low_n, 0);
        cts[0] = 1'b1;
        tick(1);
        check("d_resume_rts", rts_v[0], 1);
        check("d_resume_tx", tx_v[0], 0);
        wait_idle(0, 60);

        // Reset during data bit 3.
        wr[0]  = 1'b1;
        dat[0] = 9'h000;
        tick(1);
        wr[0] = 1'b0;
        tick(1);
        tick(17);
        check("e_tx_low_bit3", tx_v[0], 0);
        rst_n = 1'b0;
        #1;
        check("e_tx_async", tx_v[0], 1);
        check("e_empty_async", empty_v[0], 1);
        check("e_busy_async", busy_v[0], 0);
        tick(2);
        rst_n = 1'b1;
        rts_n = 0;
        low_n = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            rts_n += int'(rts_v[0]);
            low_n += int'(busy_v[0]);
        end
        check("e_no_frame_rts", rts_n, 0);
        check("e_no_frame_busy", low_n, 0);

        // 7 data bits, 1 clock per bit, 0x7F.
        cts[3] = 1'b1;
        wr[3]  = 1'b1;
        dat[3] = 9'h07F;
        tick(1);
        wr[3] = 1'b0;
        tick(1);
        seq9[0] = tx_v[3];
        rts_n   = int'(rts_v[3]);
        for (int b = 1; b < 9; b++) begin
            tick(1);
            seq9[b] = tx_v[3];
            rts_n += int'(rts_v[3]);
        end
        check("f_frame_bits", seq9, 9'b111111110);
        tick(1);
        check("f_busy_done", busy_v[3], 0);
        check("f_rts_once", rts_n, 1);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
Name: uart_tx_fifo_ctrl

Overview:
Parametrised UART transmitter, successor to the single-byte fixed-format TX. Adds configurable data width, parity, stop bits and an internal baud divider. A write FIFO lets software queue bytes back-to-back, and a CTS input provides hardware flow control. Sits between the CPU/bus write path and the serial pin; ser_clk may be the baud clock (CLKS_PER_BIT=1) or a faster system clock.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0=none, 1=odd, 2=even
STOP_BITS, 1, 1 or 2 stop bits
CLKS_PER_BIT, 1, ser_clk cycles per bit period, >=1
FIFO_DEPTH, 4, FIFO entries, power of two, >=2

Ports:
ser_clk  in  1  clock
sys_rst_i  in  1  reset
uart_wr_i  in  1  write strobe; accepted when uart_full=0
uart_dat_i  in  DATA_BITS  write data
uart_cts_i  in  1  clear-to-send, high = far end ready
uart_tx  out  1  serial output, idle high
uart_busy  out  1  high while FIFO non-empty or frame in progress
uart_full  out  1  FIFO full
uart_empty  out  1  FIFO empty
uart_ovf  out  1  one-cycle pulse: write attempted while full (data dropped)
uart_rts  out  1  one-cycle pulse on the edge a byte is loaded into the shifter

Behaviour:
- Reset: sys_rst_i is asynchronous and active-low; clock is ser_clk. During reset uart_tx=1, uart_busy=0, uart_full=0, uart_empty=1, uart_ovf=0, uart_rts=0, FIFO pointers/count=0, FSM=IDLE, bit and baud counters=0.
- Reset mid-frame aborts the frame: tx returns high asynchronously and FIFO contents are discarded.
- FIFO: a write is accepted on an edge where uart_wr_i=1 and uart_full=0. A write while full is dropped and uart_ovf pulses the next cycle. A simultaneous push and pop when full is still rejected, because full is the registered pre-edge value. A simultaneous push and pop when non-full keeps the count unchanged. Pointers wrap modulo FIFO_DEPTH. Full/empty derive from a registered count of width log2(FIFO_DEPTH)+1.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: when FIFO non-empty and uart_cts_i=1 at an edge:
  - pop the head into the shifter;
  - compute the parity bit: odd = ~^data, even = ^data;
  - drive tx=0 and go to START;
  - pulse uart_rts.
- Latency: a write at edge E0 into an empty FIFO makes tx fall at edge E1.
- Bit timing: each state bit lasts exactly CLKS_PER_BIT cycles, counted by the baud counter. The counter is reset on every state/bit change.
- Bit order after START: DATA_BITS bits LSB first, then PAR (only if PARITY!=0), then STOP_BITS bit periods with tx=1.
- End of STOP: if FIFO non-empty and cts=1, load the next byte on the same edge, with no idle gap. Otherwise go to IDLE with tx=1.
- CTS: sampled only in IDLE and at the end of STOP. Deassertion mid-frame never truncates a frame.
- uart_busy = ~empty | (state != IDLE). It is combinational from registers.
- Total frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × CLKS_PER_BIT cycles.

Decomposition:
- Package uart_pkg:
  - parity encodings PAR_NONE/PAR_ODD/PAR_EVEN;
  - FSM state enum;
  - clog2 helper.
- One sub-module, uart_tx_sync_fifo: parametrised width/depth, push/pop/full/empty/count. It has no knowledge of UART.
- The top level contains the FSM, baud counter, bit counter, shifter and parity logic.

Test Plan:
- Defaults, CLKS_PER_BIT=4, write 0xA5 -> tx falls one edge after write; sequence 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles (40 cycles total); busy drops on the cycle after the stop bit ends.
- PARITY=2, write 0xA5 -> parity bit 0. PARITY=1 -> parity bit 1. STOP_BITS=2 -> tx high for 2 bit periods before the next start.
- Write 5 bytes back-to-back with FIFO_DEPTH=4 while cts=0 -> full after 4; 5th write pulses uart_ovf and is dropped. Raise cts -> 4 frames with no idle gap between them; empty=1 and busy=0 after the last.
- Deassert cts mid-frame -> the current frame completes intact; next start is withheld until cts=1.
- Assert sys_rst_i low during the DATA bit 3 period -> tx=1 immediately; empty=1, busy=0; no further frame after release until a new write.
- DATA_BITS=7, CLKS_PER_BIT=1, write 0x7F -> 9-cycle frame: 0, seven 1s, 1; rts pulses exactly once per frame.
